dma_axi_slv: RTL
================

DMA_AXI_SLV -- requirements
Module: dma_axi_slv

Interface
REQ-001 Param TAG, default 1, width of AXI ID fields.
REQ-002 clk  in  1  single block clock.
REQ-003 rst_l  in  1  reset: asynchronous, active-low.
REQ-004 bus_clk_en  in  1  bus-rate qualifier; AXI handshakes and state updates occur only in cycles where it is 1.
REQ-005 axi_aw{valid in, ready out, id in TAG, addr in 32, size in 3, len in 8, burst in 2}: write address channel.
REQ-006 axi_w{valid in, ready out, data in 64, strb in 8, last in}: write data channel.
REQ-007 axi_b{valid out, ready in, id out TAG, resp out 2}: write response channel.
REQ-008 axi_ar{valid in, ready out, id in TAG, addr in 32, size in 3, len in 8, burst in 2}: read address channel.
REQ-009 axi_r{valid out, ready in, id out TAG, data out 64, resp out 2, last out}: read response channel.
REQ-010 dma_req{valid out, ready in, write out, addr out 32, size out 2, wdata out 64, wstrb out 8}: core DMA request port.
REQ-011 dma_rsp{valid in, error in, rdata in 64}: core DMA response, exactly one per request; no backpressure.

Function
REQ-012 Write accept: axi_awready = axi_wready = bus_clk_en & awvalid & wvalid & queue not full & ~read_grant; AW and W are always taken in the same cycle.
REQ-013 Read accept: axi_arready = bus_clk_en & arvalid & queue not full & ~write_grant.
REQ-014 When write and read are both eligible in one cycle, grant alternates; last_grant flop resets to read, so write wins first.
REQ-015 Command queue: 2 entries {write, id, addr, size[1:0], wdata, wstrb, err}; "full" = registered count==2; no push in a cycle where count==2, even if a pop occurs.
REQ-016 err set at push when len!=0, size>3, wlast==0 (writes), or addr misaligned for size.
REQ-017 FSM states IDLE, REQ, WAIT, BRESP, RRESP; resets to IDLE.
REQ-018 IDLE: queue non-empty -> pop head into the response buffer; err=0 -> REQ; err=1 -> BRESP or RRESP directly, with resp=2'b10 and no core request.
REQ-019 REQ: dma_req_valid=1 with head fields; valid & ready -> WAIT; fields stay stable while valid.
REQ-020 WAIT: dma_rsp_valid -> capture rdata and error -> BRESP (write) or RRESP (read).
REQ-021 BRESP/RRESP: bvalid or rvalid=1; resp=2'b10 if error, else 2'b00; rlast=1; id = command id; ready -> IDLE.
REQ-022 Only one core request is outstanding at a time; responses return in acceptance order regardless of type.
REQ-023 Latency, empty queue: AW/W accepted in cycle N -> dma_req_valid in cycle N+2; dma_rsp_valid in cycle M -> bvalid in M+1.
REQ-024 dma_rsp_valid outside WAIT is ignored.
REQ-025 bus_clk_en=0 freezes the FSM, queue and last_grant; all readys are 0; valids hold.
REQ-026 axi_burst is ignored; with len==0, only single-beat transfers are accepted.

Reset
REQ-027 Reset values: all valid/ready outputs 0, queue count 0, FSM IDLE, last_grant read, response buffer 0.
REQ-028 Reset asserted mid-transaction drops queued and in-flight commands; no B or R response is issued for them after reset.
REQ-029 Data and address registers need no reset; only control flops are reset.

Structure
REQ-030 Package dma_axi_pkg holds the state enum and the constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
REQ-031 Sub-module dma_axi_cmdq: 2-entry FIFO with push, pop, full, empty and head outputs, instantiated once.
REQ-032 Flops use the codebase's standard flop/clock-header library cells; target is 200-350 lines of RTL.

Verification
REQ-033 Write addr 0x1000, size 2, strb 0x0F, id 1 -> dma_req write addr 0x1000 wstrb 0x0F; rsp ok -> bid 1, bresp 00.
REQ-034 Read addr 0x2008, size 3; rsp rdata 0xDEADBEEF_CAFEF00D, error 1 -> rdata same, rresp 10, rlast 1.
REQ-035 awlen=3 -> no dma_req_valid; bresp 10 with the matching id.
REQ-036 AW/W and AR presented together on 4 consecutive grants -> order W, R, W, R; responses in that order.
REQ-037 Hold dma_req_ready=0 until two commands are queued -> awready/arready stay 0 until the first pop.
REQ-038 Pulse rst_l low while in WAIT -> no B/R valid afterward; FSM IDLE, queue count 0.

Source files
------------

// File: rtl/dma_axi_pkg.sv
// Shared types and helpers for the AXI-to-DMA slave bridge.
package dma_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_BRESP,
        ST_RRESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic GRANT_READ  = 1'b0;
    localparam logic GRANT_WRITE = 1'b1;

    // Only single-beat, naturally aligned transfers of up to 8 bytes are served.
    function automatic logic cmd_err(input logic [7:0] len, input logic [2:0] size,
                                     input logic [2:0] addr_lo, input logic is_write,
                                     input logic wlast);
        logic misaligned;
        case (size)
            3'd0:    misaligned = 1'b0;
            3'd1:    misaligned = addr_lo[0];
            3'd2:    misaligned = |addr_lo[1:0];
            3'd3:    misaligned = |addr_lo;
            default: misaligned = 1'b1;
        endcase
        return (len != 8'd0) || (size > 3'd3) || (is_write && !wlast) || misaligned;
    endfunction

endpackage

// File: rtl/dma_axi_cmdq.sv
// Two-entry command FIFO between the AXI accept logic and the core request FSM.
module dma_axi_cmdq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/dma_axi_slv.sv
// AXI slave front-end that serialises single-beat reads/writes into one-at-a-time core DMA requests.
module dma_axi_slv #(
    parameter int TAG = 1
) (
    input  logic           clk,
    input  logic           rst_l,
    input  logic           bus_clk_en,

    input  logic           axi_awvalid,
    output logic           axi_awready,
    input  logic [TAG-1:0] axi_awid,
    input  logic [31:0]    axi_awaddr,
    input  logic [2:0]     axi_awsize,
    input  logic [7:0]     axi_awlen,
    input  logic [1:0]     axi_awburst,

    input  logic           axi_wvalid,
    output logic           axi_wready,
    input  logic [63:0]    axi_wdata,
    input  logic [7:0]     axi_wstrb,
    input  logic           axi_wlast,

    output logic           axi_bvalid,
    input  logic           axi_bready,
    output logic [TAG-1:0] axi_bid,
    output logic [1:0]     axi_bresp,

    input  logic           axi_arvalid,
    output logic           axi_arready,
    input  logic [TAG-1:0] axi_arid,
    input  logic [31:0]    axi_araddr,
    input  logic [2:0]     axi_arsize,
    input  logic [7:0]     axi_arlen,
    input  logic [1:0]     axi_arburst,

    output logic           axi_rvalid,
    input  logic           axi_rready,
    output logic [TAG-1:0] axi_rid,
    output logic [63:0]    axi_rdata,
    output logic [1:0]     axi_rresp,
    output logic           axi_rlast,

    output logic           dma_req_valid,
    input  logic           dma_req_ready,
    output logic           dma_req_write,
    output logic [31:0]    dma_req_addr,
    output logic [1:0]     dma_req_size,
    output logic [63:0]    dma_req_wdata,
    output logic [7:0]     dma_req_wstrb,

    input  logic           dma_rsp_valid,
    input  logic           dma_rsp_error,
    input  logic [63:0]    dma_rsp_rdata
);
    import dma_axi_pkg::*;

    localparam int ENTRY_W = 1 + TAG + 32 + 2 + 64 + 8 + 1;

    state_t         state;
    logic           last_grant;
    logic           q_full;
    logic           q_empty;
    logic           pop;
    logic           wr_elig;
    logic           rd_elig;
    logic           write_grant;
    logic           read_grant;
    logic           wr_err;
    logic           rd_err;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head;

    logic           h_write;
    logic [TAG-1:0] h_id;
    logic [31:0]    h_addr;
    logic [1:0]     h_size;
    logic [63:0]    h_wdata;
    logic [7:0]     h_wstrb;
    logic           h_err;

    logic           rsp_write;
    logic           rsp_err;
    logic [TAG-1:0] rsp_id;
    logic [63:0]    rsp_rdata;

    logic           unused_burst;
    assign unused_burst = ^{axi_awburst, axi_arburst};

    // Arbitration: when both channels are eligible, the one not granted last wins.
    assign wr_elig     = axi_awvalid & axi_wvalid & ~q_full;
    assign rd_elig     = axi_arvalid & ~q_full;
    assign write_grant = bus_clk_en & wr_elig & (~rd_elig | (last_grant == GRANT_READ));
    assign read_grant  = bus_clk_en & rd_elig & (~wr_elig | (last_grant == GRANT_WRITE));

    assign axi_awready = write_grant;
    assign axi_wready  = write_grant;
    assign axi_arready = read_grant;

    assign wr_err = cmd_err(axi_awlen, axi_awsize, axi_awaddr[2:0], 1'b1, axi_wlast);
    assign rd_err = cmd_err(axi_arlen, axi_arsize, axi_araddr[2:0], 1'b0, 1'b1);

    assign push_data = write_grant
        ? {1'b1, axi_awid, axi_awaddr, axi_awsize[1:0], axi_wdata, axi_wstrb, wr_err}
        : {1'b0, axi_arid, axi_araddr, axi_arsize[1:0], 64'd0, 8'd0, rd_err};

    assign {h_write, h_id, h_addr, h_size, h_wdata, h_wstrb, h_err} = head;

    assign pop = bus_clk_en & (state == ST_IDLE) & ~q_empty;

    dma_axi_cmdq #(.W(ENTRY_W)) u_cmdq (
        .clk       (clk),
        .rst_l     (rst_l),
        .push      (write_grant | read_grant),
        .push_data (push_data),
        .pop       (pop),
        .full      (q_full),
        .empty     (q_empty),
        .head      (head)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state         <= ST_IDLE;
            last_grant    <= GRANT_READ;
            dma_req_valid <= 1'b0;
            axi_bvalid    <= 1'b0;
            axi_rvalid    <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_err       <= 1'b0;
            rsp_id        <= '0;
            rsp_rdata     <= '0;
        end else if (bus_clk_en) begin
            if (write_grant)     last_grant <= GRANT_WRITE;
            else if (read_grant) last_grant <= GRANT_READ;

            case (state)
                ST_IDLE: begin
                    if (!q_empty) begin
                        rsp_write <= h_write;
                        rsp_id    <= h_id;
                        rsp_err   <= h_err;
                        if (h_err) begin
                            // Malformed commands are answered directly without touching the core.
                            rsp_rdata <= '0;
                            if (h_write) begin
                                state      <= ST_BRESP;
                                axi_bvalid <= 1'b1;
                            end else begin
                                state      <= ST_RRESP;
                                axi_rvalid <= 1'b1;
                            end
                        end else begin
                            state         <= ST_REQ;
                            dma_req_valid <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (dma_req_ready) begin
                        state         <= ST_WAIT;
                        dma_req_valid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (dma_rsp_valid) begin
                        rsp_rdata <= dma_rsp_rdata;
                        rsp_err   <= dma_rsp_error;
                        if (rsp_write) begin
                            state      <= ST_BRESP;
                            axi_bvalid <= 1'b1;
                        end else begin
                            state      <= ST_RRESP;
                            axi_rvalid <= 1'b1;
                        end
                    end
                end
                ST_BRESP: begin
                    if (axi_bready) begin
                        state      <= ST_IDLE;
                        axi_bvalid <= 1'b0;
                    end
                end
                ST_RRESP: begin
                    if (axi_rready) begin
                        state      <= ST_IDLE;
                        axi_rvalid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Request fields are loaded on pop and stay stable for the life of the request.
    always_ff @(posedge clk) begin
        if (pop) begin
            dma_req_write <= h_write;
            dma_req_addr  <= h_addr;
            dma_req_size  <= h_size;
            dma_req_wdata <= h_wdata;
            dma_req_wstrb <= h_wstrb;
        end
    end

    assign axi_bid   = rsp_id;
    assign axi_rid   = rsp_id;
    assign axi_bresp = rsp_err ? RESP_SLVERR : RESP_OKAY;
    assign axi_rresp = rsp_err ? RESP_SLVERR : RESP_OKAY;
    assign axi_rdata = rsp_rdata;
    assign axi_rlast = 1'b1;

endmodule
